// File: rtl/fft_delay_commutator.sv
// Two-lane delay-commutator for pipelined radix-2 FFTs: delays lane b, swaps lanes in
// blocks of DEPTH pairs, then re-aligns lane a. All state advances only on accepted pairs.
module fft_delay_commutator #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              frame_start,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic              out_valid,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out
);
    localparam int PW = $clog2(DEPTH) + 1;

    logic [PW-1:0]                phase_q, phase_d, fill_q, fill_d, p;
    logic [DEPTH-1:0][DATA_W-1:0] pre_q, pre_d, post_q, post_d;
    logic                         out_valid_q, s, full;
    logic [DATA_W-1:0]            a_out_q, b_out_q, bd, x0, x1;

    always_comb begin
        // frame_start forces this pair to phase 0; the MSB of the phase selects the swap half
        p       = frame_start ? '0 : phase_q;
        s       = p[PW-1];
        phase_d = p + PW'(1);
        full    = (fill_q == PW'(DEPTH));
        fill_d  = full ? fill_q : fill_q + PW'(1);
        bd      = pre_q[DEPTH-1];
        x0      = s ? bd   : a_in;
        x1      = s ? a_in : bd;
        pre_d   = pre_q;
        post_d  = post_q;
        pre_d[0]  = b_in;
        post_d[0] = x0;
        for (int i = 1; i < DEPTH; i++) begin
            pre_d[i]  = pre_q[i-1];
            post_d[i] = post_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q     <= '0;
            fill_q      <= '0;
            pre_q       <= '0;
            post_q      <= '0;
            out_valid_q <= 1'b0;
            a_out_q     <= '0;
            b_out_q     <= '0;
        end else if (in_valid) begin
            phase_q     <= phase_d;
            fill_q      <= fill_d;
            pre_q       <= pre_d;
            post_q      <= post_d;
            out_valid_q <= full;
            a_out_q     <= post_q[DEPTH-1];
            b_out_q     <= x1;
        end else begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign a_out     = a_out_q;
    assign b_out     = b_out_q;
endmodule

// File: tb/tb_fft_delay_commutator.sv
// Directed bench: DEPTH=2, DEPTH=8/16-bit and DEPTH=1 instances driven one at a time
// with hand-computed expected pairs, idle gaps, mid-stream reset and frame resync.
module tb_fft_delay_commutator;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        r2, v2, f2, ov2;
    logic [31:0] a2, b2, ao2, bo2;
    logic        r8, v8, f8, ov8;
    logic [15:0] a8, b8, ao8, bo8;
    logic        r1, v1, f1, ov1;
    logic [31:0] a1, b1, ao1, bo1;

    fft_delay_commutator #(.DATA_W(32), .DEPTH(2)) u_d2 (
        .clk(clk), .rst(r2), .in_valid(v2), .frame_start(f2), .a_in(a2), .b_in(b2),
        .out_valid(ov2), .a_out(ao2), .b_out(bo2));
    fft_delay_commutator #(.DATA_W(16), .DEPTH(8)) u_d8 (
        .clk(clk), .rst(r8), .in_valid(v8), .frame_start(f8), .a_in(a8), .b_in(b8),
        .out_valid(ov8), .a_out(ao8), .b_out(bo8));
    fft_delay_commutator #(.DATA_W(32), .DEPTH(1)) u_d1 (
        .clk(clk), .rst(r1), .in_valid(v1), .frame_start(f1), .a_in(a1), .b_in(b1),
        .out_valid(ov1), .a_out(ao1), .b_out(bo1));

    int e2a[8] = '{0, 1, 100, 101, 4, 5, 104, 105};
    int e2b[8] = '{2, 3, 102, 103, 6, 7, 106, 107};
    int e1a[5] = '{0, 100, 2, 102, 4};
    int e1b[5] = '{1, 101, 3, 103, 5};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Full DEPTH=2 stream from a fresh reset; zero outputs while filling exposes stale data
    task automatic stream2(input string tag);
        for (int k = 0; k < 10; k++) begin
            a2 = 32'(k); b2 = 32'(100 + k); v2 = 1'b1; f2 = (k == 0);
            tick;
            chk({tag, "_valid"}, 32'(ov2), 32'(k >= 2));
            chk({tag, "_a"}, ao2, (k >= 2) ? 32'(e2a[k-2]) : 32'd0);
            chk({tag, "_b"}, bo2, (k >= 2) ? 32'(e2b[k-2]) : 32'd0);
        end
        v2 = 1'b0; f2 = 1'b0;
    endtask

    initial begin
        logic [19:0] idle_pat;
        logic [31:0] lastA, lastB;
        logic [15:0] ah[64], bh[64], x0h[64];
        logic [15:0] bd, x0, x1, la8, lb8;
        int k, pc, p;
        logic fs;

        r2 = 1'b1; v2 = 1'b0; f2 = 1'b0; a2 = '0; b2 = '0;
        r8 = 1'b1; v8 = 1'b0; f8 = 1'b0; a8 = '0; b8 = '0;
        r1 = 1'b1; v1 = 1'b0; f1 = 1'b0; a1 = '0; b1 = '0;
        tick;
        r2 = 1'b0; r8 = 1'b0; r1 = 1'b0;
        chk("rst_valid", 32'(ov2), 32'd0);
        chk("rst_a", ao2, 32'd0);
        chk("rst_b", bo2, 32'd0);

        // Test 1: continuous stream
        stream2("t1");

        // Test 2: same stream with idle gaps
        r2 = 1'b1; tick; r2 = 1'b0;
        idle_pat = 20'b0100_1001_0010_0110_0100;
        lastA = '0; lastB = '0; k = 0;
        for (int c = 0; c < 20; c++) begin
            if (k < 10) begin
                if (idle_pat[c]) begin
                    v2 = 1'b0; a2 = 32'd999; b2 = 32'd999; f2 = 1'b0;
                    tick;
                    chk("t2_idle_valid", 32'(ov2), 32'd0);
                    chk("t2_idle_a", ao2, lastA);
                    chk("t2_idle_b", bo2, lastB);
                end else begin
                    v2 = 1'b1; a2 = 32'(k); b2 = 32'(100 + k); f2 = (k == 0);
                    tick;
                    chk("t2_valid", 32'(ov2), 32'(k >= 2));
                    if (k >= 2) begin
                        lastA = 32'(e2a[k-2]); lastB = 32'(e2b[k-2]);
                    end
                    chk("t2_a", ao2, lastA);
                    chk("t2_b", bo2, lastB);
                    k++;
                end
            end
        end
        v2 = 1'b0;
        chk("t2_pairs_done", 32'(k), 32'd10);

        // Test 3: reset mid-stream after 5 pairs
        r2 = 1'b1; tick; r2 = 1'b0;
        for (int j = 0; j < 5; j++) begin
            a2 = 32'(j); b2 = 32'(100 + j); v2 = 1'b1; f2 = (j == 0);
            tick;
        end
        chk("t3_pre_valid", 32'(ov2), 32'd1);
        chk("t3_pre_a", ao2, 32'd100);
        r2 = 1'b1; v2 = 1'b0; tick; r2 = 1'b0;
        chk("t3_rst_valid", 32'(ov2), 32'd0);
        chk("t3_rst_a", ao2, 32'd0);
        chk("t3_rst_b", bo2, 32'd0);
        stream2("t3");

        // Test 6: pair presented with reset is dropped
        r2 = 1'b1; v2 = 1'b1; a2 = 32'd55; b2 = 32'd55; tick;
        r2 = 1'b0; v2 = 1'b0;
        chk("t6_rst_valid", 32'(ov2), 32'd0);
        chk("t6_rst_a", ao2, 32'd0);
        chk("t6_rst_b", bo2, 32'd0);
        stream2("t6");

        // Test 5: DEPTH=1 toggles swap every pair
        r1 = 1'b1; tick; r1 = 1'b0;
        for (int j = 0; j < 6; j++) begin
            a1 = 32'(j); b1 = 32'(100 + j); v1 = 1'b1; f1 = (j == 0);
            tick;
            chk("t5_valid", 32'(ov1), 32'(j >= 1));
            if (j >= 1) begin
                chk("t5_a", ao1, 32'(e1a[j-1]));
                chk("t5_b", bo1, 32'(e1b[j-1]));
            end
        end
        v1 = 1'b0;

        // Test 4: DEPTH=8 with frame resync at k=21; stray frame_start on an idle cycle
        r8 = 1'b1; tick; r8 = 1'b0;
        k = 0; pc = 0; la8 = '0; lb8 = '0;
        for (int c = 0; c < 45; c++) begin
            if (c == 30) begin
                v8 = 1'b0; f8 = 1'b1; a8 = 16'hdead; b8 = 16'hbeef;
                tick;
                chk("t4_idle_valid", 32'(ov8), 32'd0);
                chk("t4_idle_a", 32'(ao8), 32'(la8));
                chk("t4_idle_b", 32'(bo8), 32'(lb8));
            end else begin
                fs = (k == 0) || (k == 21);
                ah[k] = 16'(16'h1000 + k); bh[k] = 16'(16'h2000 + k);
                p  = fs ? 0 : pc;
                bd = (k >= 8) ? bh[k-8] : 16'd0;
                x0 = (p >= 8) ? bd : ah[k];
                x1 = (p >= 8) ? ah[k] : bd;
                x0h[k] = x0;
                pc = (p + 1) % 16;
                la8 = (k >= 8) ? x0h[k-8] : 16'd0;
                lb8 = x1;
                v8 = 1'b1; f8 = fs; a8 = ah[k]; b8 = bh[k];
                tick;
                chk("t4_valid", 32'(ov8), 32'(k >= 8));
                chk("t4_a", 32'(ao8), 32'(la8));
                chk("t4_b", 32'(bo8), 32'(lb8));
                k++;
            end
        end
        v8 = 1'b0; f8 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
